game_status_block: RTL and testbench

Game-state tracker that sits directly upstream of the on-screen indications stage. It owns the life count, score count and current target number (scoreNumber), and the play/lose/over/won state machine. It consumes collision events and frame ticks, and drives the 4-bit life/score/scoreNumber values that the indications stage renders.

---
 rtl/game_pkg.sv | 33 +++
 rtl/rise_edge_detect.sv | 25 ++
 rtl/game_status_block.sv | 142 ++++++++++++++
 tb/tb_game_status_block.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, constants and the target-number mapping for the game status block.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    LOSE_DELAY = 2'd1,
    GAME_OVER  = 2'd2,
    WON        = 2'd3
  } state_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [3:0] next_target(input logic [3:0] rnd, input logic [3:0] current);
    logic [3:0] n;
    n = rnd;
    if (n == 4'd0) begin
      n = 4'd1;
    end else if (n > DIGIT_MAX) begin
      n = n - 4'd6;
    end else begin
      n = n;
    end
    if (n == current) begin
      n = (n == DIGIT_MAX) ? 4'd1 : (n + 4'd1);
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registers a level input and emits a registered one-clock pulse on its rising edge.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;
  logic pulse_q;

  // Delay the level once and register the rise so downstream logic sees a clean pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      in_q    <= in_i;
      pulse_q <= in_i & ~in_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_status_block.sv
// Game-state tracker: lives, score, current target number and the play/lose/over/won flow.
module game_status_block
  import game_pkg::*;
#(
  parameter logic [3:0] INIT_LIFE      = 4'd3,
  parameter logic [3:0] WIN_SCORE      = 4'd9,
  parameter int         RESPAWN_FRAMES = 60,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       ballLost,
  input  logic       hitValid,
  input  logic [3:0] hitNumber,
  output logic [3:0] life,
  output logic [3:0] score,
  output logic [3:0] scoreNumber,
  output logic       gameOver,
  output logic       gameWon,
  output logic       ballRespawn
);

  localparam int FW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(RESPAWN_FRAMES - 1);

  state_t        state_q, state_d;
  logic [3:0]    life_q, life_d;
  logic [3:0]    score_q, score_d;
  logic [3:0]    sn_q, sn_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    hit_num_q;
  logic          respawn_q, respawn_d;
  logic          over_q, over_d;
  logic          won_q, won_d;

  logic start_ev_s, lost_ev_s, hit_ev_s, hit_ok_s;

  rise_edge_detect u_start (.clk(clk), .rst_n(resetN), .in_i(startGame), .pulse_o(start_ev_s));
  rise_edge_detect u_lost  (.clk(clk), .rst_n(resetN), .in_i(ballLost),  .pulse_o(lost_ev_s));
  rise_edge_detect u_hit   (.clk(clk), .rst_n(resetN), .in_i(hitValid),  .pulse_o(hit_ev_s));

  assign lfsr_d   = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  // hit_num_q holds hitNumber from the cycle the rise was seen, aligned with hit_ev_s.
  assign hit_ok_s = hit_ev_s && (hit_num_q == sn_q) && (score_q < WIN_SCORE);

  // Next-state and output computation for the game flow.
  always_comb begin
    state_d   = state_q;
    life_d    = life_q;
    score_d   = score_q;
    sn_d      = sn_q;
    frame_d   = frame_q;
    respawn_d = 1'b0;
    if (start_ev_s) begin
      state_d   = PLAY;
      life_d    = INIT_LIFE;
      score_d   = 4'd0;
      sn_d      = next_target(lfsr_q[3:0], sn_q);
      frame_d   = {FW{1'b0}};
      respawn_d = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit_ok_s) begin
            score_d = score_q + 4'd1;
            sn_d    = next_target(lfsr_q[3:0], sn_q);
          end else begin
            score_d = score_q;
          end
          // A winning hit pre-empts a simultaneous ball loss.
          if (hit_ok_s && ((score_q + 4'd1) == WIN_SCORE)) begin
            state_d = WON;
          end else if (lost_ev_s && (life_q != 4'd0)) begin
            life_d = life_q - 4'd1;
            if (life_q == 4'd1) begin
              state_d = GAME_OVER;
            end else begin
              state_d = LOSE_DELAY;
              frame_d = {FW{1'b0}};
            end
          end else begin
            state_d = PLAY;
          end
        end
        LOSE_DELAY: begin
          if (startOfFrame && (frame_q == FRAME_LAST)) begin
            respawn_d = 1'b1;
            state_d   = PLAY;
            frame_d   = {FW{1'b0}};
          end else if (startOfFrame) begin
            frame_d = frame_q + FW'(1);
          end else begin
            frame_d = frame_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    over_d = (state_d == GAME_OVER);
    won_d  = (state_d == WON);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= PLAY;
      life_q    <= INIT_LIFE;
      score_q   <= 4'd0;
      sn_q      <= 4'd5;
      frame_q   <= {FW{1'b0}};
      lfsr_q    <= LFSR_SEED;
      hit_num_q <= 4'd0;
      respawn_q <= 1'b0;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      life_q    <= life_d;
      score_q   <= score_d;
      sn_q      <= sn_d;
      frame_q   <= frame_d;
      lfsr_q    <= lfsr_d;
      hit_num_q <= hitNumber;
      respawn_q <= respawn_d;
      over_q    <= over_d;
      won_q     <= won_d;
    end
  end

  assign life        = life_q;
  assign score       = score_q;
  assign scoreNumber = sn_q;
  assign gameOver    = over_q;
  assign gameWon     = won_q;
  assign ballRespawn = respawn_q;

endmodule

// File: tb/tb_game_status_block.sv
// Randomized and directed bench for game_status_block against a rule-level reference model.
module tb_game_status_block;

  localparam int INIT = 3;
  localparam int WIN = 9;
  localparam int FRAMES = 60;
  localparam int M_PLAY = 0, M_DELAY = 1, M_OVER = 2, M_WON = 3;

  logic       clk, resetN, startOfFrame, startGame, ballLost, hitValid;
  logic [3:0] hitNumber, life, score, scoreNumber;
  logic       gameOver, gameWon, ballRespawn;

  int n_cmp = 0, n_mis = 0;

  // reference model state
  int m_life, m_score, m_sn, m_mode, m_frames, m_resp, m_lfsr;
  int m_sg_d, m_bl_d, m_hv_d, m_sg_ev, m_bl_ev, m_hv_ev, m_hn_q;

  game_status_block dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .ballLost(ballLost), .hitValid(hitValid), .hitNumber(hitNumber),
    .life(life), .score(score), .scoreNumber(scoreNumber),
    .gameOver(gameOver), .gameWon(gameWon), .ballRespawn(ballRespawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick_target(input int rnd, input int cur);
    int n;
    n = rnd % 16;
    if (n == 0) n = 1;
    if (n >= 10) n = n - 6;
    if (n == cur) n = (n % 9) + 1;
    return n;
  endfunction

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  task automatic model_reset();
    m_life = INIT; m_score = 0; m_sn = 5; m_mode = M_PLAY; m_frames = 0; m_resp = 0;
    m_lfsr = 8'hA5;
    m_sg_d = 0; m_bl_d = 0; m_hv_d = 0; m_sg_ev = 0; m_bl_ev = 0; m_hv_ev = 0; m_hn_q = 0;
  endtask

  task automatic model_step();
    m_resp = 0;
    if (m_sg_ev == 1) begin
      m_life = INIT; m_score = 0; m_sn = pick_target(m_lfsr, m_sn);
      m_mode = M_PLAY; m_frames = 0; m_resp = 1;
    end else if (m_mode == M_PLAY) begin
      if (m_hv_ev == 1 && m_hn_q == m_sn && m_score < WIN) begin
        m_score++;
        m_sn = pick_target(m_lfsr, m_sn);
        if (m_score == WIN) m_mode = M_WON;
      end
      if (m_mode == M_PLAY && m_bl_ev == 1 && m_life > 0) begin
        m_life--;
        if (m_life == 0) m_mode = M_OVER;
        else begin m_mode = M_DELAY; m_frames = 0; end
      end
    end else if (m_mode == M_DELAY && startOfFrame) begin
      m_frames++;
      if (m_frames == FRAMES) begin m_resp = 1; m_mode = M_PLAY; end
    end
    m_sg_ev = (startGame && m_sg_d == 0) ? 1 : 0; m_sg_d = int'(startGame);
    m_bl_ev = (ballLost && m_bl_d == 0) ? 1 : 0;  m_bl_d = int'(ballLost);
    m_hv_ev = (hitValid && m_hv_d == 0) ? 1 : 0;  m_hv_d = int'(hitValid);
    m_hn_q = int'(hitNumber);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    check_eq("life", int'(life), m_life);
    check_eq("score", int'(score), m_score);
    check_eq("scoreNumber", int'(scoreNumber), m_sn);
    check_eq("gameOver", int'(gameOver), (m_mode == M_OVER) ? 1 : 0);
    check_eq("gameWon", int'(gameWon), (m_mode == M_WON) ? 1 : 0);
    check_eq("ballRespawn", int'(ballRespawn), m_resp);
    check_eq("sn_range", (scoreNumber >= 4'd1 && scoreNumber <= 4'd9) ? 1 : 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetN) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_hit(input int num);
    hitNumber = 4'(num); hitValid = 1'b1; tick();
    hitValid = 1'b0; tick(); tick();
  endtask

  task automatic pulse_lost();
    ballLost = 1'b1; tick();
    ballLost = 1'b0; tick(); tick();
  endtask

  task automatic restart();
    startGame = 1'b1; tick();
    startGame = 1'b0; tick(); tick();
  endtask

  // Issues count frame pulses and returns how many respawns appeared and when the first did.
  task automatic run_frames(input int count, output int resp_cnt, output int resp_at);
    resp_cnt = 0; resp_at = -1;
    for (int i = 0; i < count; i++) begin
      startOfFrame = 1'b1; tick();
      if (ballRespawn) begin resp_cnt++; if (resp_at < 0) resp_at = i + 1; end
      startOfFrame = 1'b0; tick();
      if (ballRespawn) resp_cnt++;
    end
  endtask

  initial begin
    int rc, ra;
    resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0; ballLost = 1'b0;
    hitValid = 1'b0; hitNumber = 4'd0;
    model_reset();
    tick(); tick();
    check_eq("rst_life", int'(life), 3);
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_sn", int'(scoreNumber), 5);
    check_eq("rst_over", int'(gameOver), 0);
    resetN = 1'b1;
    tick(); tick();
    check_eq("lfsr_model", int'(dut.lfsr_q), m_lfsr);
    check_eq("lfsr_moved", (dut.lfsr_q != 8'hA5) ? 1 : 0, 1);

    // held hit level counts once
    hitNumber = 4'd5; hitValid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    hitValid = 1'b0; tick();
    check_eq("hold_score", int'(score), 1);
    check_eq("hold_sn_new", (scoreNumber != 4'd5) ? 1 : 0, 1);
    pulse_hit((m_sn % 9) + 1);
    check_eq("miss_score", int'(score), 1);

    // ball lost, hit ignored in delay, respawn on 60th frame
    pulse_lost();
    check_eq("lost_life", int'(life), 2);
    pulse_hit(m_sn);
    check_eq("delay_hit_ignored", int'(score), 1);
    run_frames(FRAMES, rc, ra);
    check_eq("respawn_count", rc, 1);
    check_eq("respawn_frame", ra, FRAMES);

    // run out of lives, then restart
    pulse_lost();
    run_frames(FRAMES, rc, ra);
    pulse_lost();
    check_eq("over_life", int'(life), 0);
    check_eq("over_flag", int'(gameOver), 1);
    pulse_lost();
    check_eq("no_underflow", int'(life), 0);
    startGame = 1'b1; tick(); tick();
    check_eq("restart_respawn", int'(ballRespawn), 1);
    startGame = 1'b0; tick();
    check_eq("restart_life", int'(life), 3);
    check_eq("restart_score", int'(score), 0);
    check_eq("restart_over", int'(gameOver), 0);

    // score 8, then matching hit together with ball loss
    for (int i = 0; i < 8; i++) pulse_hit(m_sn);
    check_eq("score8", int'(score), 8);
    hitNumber = 4'(m_sn); hitValid = 1'b1; ballLost = 1'b1; tick();
    hitValid = 1'b0; ballLost = 1'b0; tick(); tick();
    check_eq("win_score", int'(score), 9);
    check_eq("win_flag", int'(gameWon), 1);
    check_eq("win_life", int'(life), 3);

    // async reset in the middle of a respawn delay
    restart();
    pulse_lost();
    run_frames(30, rc, ra);
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check_eq("async_life", int'(life), 3);
    check_eq("async_score", int'(score), 0);
    check_eq("async_sn", int'(scoreNumber), 5);
    check_eq("async_over", int'(gameOver), 0);
    check_eq("async_resp", int'(ballRespawn), 0);
    tick(); tick();
    resetN = 1'b1;
    run_frames(40, rc, ra);
    check_eq("no_respawn_after_rst", rc, 0);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      startGame    = ($urandom_range(0, 299) == 0);
      ballLost     = ($urandom_range(0, 39) == 0);
      hitValid     = ($urandom_range(0, 5) == 0);
      hitNumber    = ($urandom_range(0, 1) == 0) ? 4'(m_sn) : 4'($urandom_range(0, 15));
      startOfFrame = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
